// File: rtl/instr_byte_assembler_pkg.sv
// Shared constants for the instruction byte assembler: prefix/escape byte values,
// segment override encodings, prefix group indices and FSM state encodings.
package instr_byte_assembler_pkg;

  localparam logic [7:0] PFX_OPSIZE   = 8'h66;
  localparam logic [7:0] PFX_ADDRSIZE = 8'h67;
  localparam logic [7:0] PFX_LOCK     = 8'hF0;
  localparam logic [7:0] PFX_REPNE    = 8'hF2;
  localparam logic [7:0] PFX_REP      = 8'hF3;
  localparam logic [7:0] PFX_SEG_ES   = 8'h26;
  localparam logic [7:0] PFX_SEG_CS   = 8'h2E;
  localparam logic [7:0] PFX_SEG_SS   = 8'h36;
  localparam logic [7:0] PFX_SEG_DS   = 8'h3E;
  localparam logic [7:0] PFX_SEG_FS   = 8'h64;
  localparam logic [7:0] PFX_SEG_GS   = 8'h65;
  localparam logic [7:0] ESC_0F       = 8'h0F;

  localparam logic [2:0] SEG_NONE = 3'd0;
  localparam logic [2:0] SEG_ES   = 3'd1;
  localparam logic [2:0] SEG_CS   = 3'd2;
  localparam logic [2:0] SEG_SS   = 3'd3;
  localparam logic [2:0] SEG_DS   = 3'd4;
  localparam logic [2:0] SEG_FS   = 3'd5;
  localparam logic [2:0] SEG_GS   = 3'd6;

  // Bit positions in the one-hot prefix group vector.
  localparam int GRP_LOCKREP  = 0;
  localparam int GRP_SEG      = 1;
  localparam int GRP_OPSIZE   = 2;
  localparam int GRP_ADDRSIZE = 3;
  localparam int GRP_W        = 4;

  typedef enum logic [2:0] {
    S_PREFIX = 3'd0,
    S_ESC    = 3'd1,
    S_BODY   = 3'd2,
    S_DRAIN  = 3'd3,
    S_EMIT   = 3'd4
  } state_t;

  function automatic logic [3:0] sat_inc4(input logic [3:0] v);
    return (v == 4'hF) ? v : v + 4'd1;
  endfunction

endpackage

// File: rtl/instr_byte_assembler_if.sv
// Byte-in / instruction-out bus of the instruction byte assembler.
// Exposes the FSM state as state_dbg for checkers.
interface instr_byte_assembler_if #(
  parameter int BODY_BYTES = 9
);
  import instr_byte_assembler_pkg::*;

  // Both sides use strict valid/ready: a transfer happens on a clock edge where
  // valid && ready; the sender holds its payload stable and may not drop valid
  // until the transfer; ready may not depend combinationally on valid.
  logic [7:0]              in_byte;
  logic                    in_valid;
  logic                    in_last;
  logic                    in_ready;
  logic                    out_valid;
  logic                    out_ready;
  logic [8*BODY_BYTES-1:0] unescaped_instr;
  logic [3:0]              instr_len;
  logic                    is_escaped;
  logic                    prefix_operand_16bit;
  logic                    prefix_address_16bit;
  logic                    prefix_lock;
  logic                    prefix_rep;
  logic                    prefix_repne;
  logic [2:0]              prefix_seg;
  logic                    err;
  state_t                  state_dbg;

  modport master (
    output in_byte, in_valid, in_last, out_ready,
    input  in_ready, out_valid, unescaped_instr, instr_len, is_escaped,
           prefix_operand_16bit, prefix_address_16bit, prefix_lock, prefix_rep,
           prefix_repne, prefix_seg, err, state_dbg
  );

  modport slave (
    input  in_byte, in_valid, in_last, out_ready,
    output in_ready, out_valid, unescaped_instr, instr_len, is_escaped,
           prefix_operand_16bit, prefix_address_16bit, prefix_lock, prefix_rep,
           prefix_repne, prefix_seg, err, state_dbg
  );

endinterface

// File: rtl/instr_byte_assembler_prefix_classify.sv
// Combinational legacy-prefix classifier: flags prefix bytes, reports their
// group as a one-hot vector and decodes the segment override code.
module instr_byte_assembler_prefix_classify
  import instr_byte_assembler_pkg::*;
(
  input  logic [7:0]       in_byte,
  output logic             is_prefix,
  output logic [GRP_W-1:0] grp,
  output logic [2:0]       seg_code
);

  always_comb begin
    grp      = '0;
    seg_code = SEG_NONE;
    case (in_byte)
      PFX_OPSIZE:   grp[GRP_OPSIZE]   = 1'b1;
      PFX_ADDRSIZE: grp[GRP_ADDRSIZE] = 1'b1;
      PFX_LOCK,
      PFX_REP,
      PFX_REPNE:    grp[GRP_LOCKREP]  = 1'b1;
      PFX_SEG_ES: begin grp[GRP_SEG] = 1'b1; seg_code = SEG_ES; end
      PFX_SEG_CS: begin grp[GRP_SEG] = 1'b1; seg_code = SEG_CS; end
      PFX_SEG_SS: begin grp[GRP_SEG] = 1'b1; seg_code = SEG_SS; end
      PFX_SEG_DS: begin grp[GRP_SEG] = 1'b1; seg_code = SEG_DS; end
      PFX_SEG_FS: begin grp[GRP_SEG] = 1'b1; seg_code = SEG_FS; end
      PFX_SEG_GS: begin grp[GRP_SEG] = 1'b1; seg_code = SEG_GS; end
      default: ;
    endcase
  end

  assign is_prefix = |grp;

endmodule

// File: rtl/instr_byte_assembler.sv
// Packs a stream of raw x86 instruction bytes into prefix flags, escape flag,
// length and the unescaped body word. Optional macro: INSTR_STRICT_PREFIX_EN.
module instr_byte_assembler
  import instr_byte_assembler_pkg::*;
#(
  parameter int BODY_BYTES   = 9,
  parameter int MAX_PREFIXES = 4
) (
  input logic                    clk,
  input logic                    rst,
  instr_byte_assembler_if.slave  bus
);

  localparam int BCW = $clog2(BODY_BYTES + 1);
  localparam int PCW = $clog2(MAX_PREFIXES + 1);
  localparam logic [BCW-1:0] BODY_FULL = BCW'(BODY_BYTES);
  localparam logic [PCW-1:0] PFX_FULL  = PCW'(MAX_PREFIXES);

  state_t state_q, state_d;

  logic [8*BODY_BYTES-1:0] body_q;
  logic [BCW-1:0]          body_cnt_q;
  logic [PCW-1:0]          prefix_cnt_q;
  logic [3:0]              len_q;
  logic                    esc_q, op16_q, addr16_q, lock_q, rep_q, repne_q, err_q;
  logic [2:0]              seg_q;

  logic             is_prefix;
  logic [GRP_W-1:0] grp;
  logic [2:0]       seg_code;

  logic in_ready_w, out_valid_w;

  instr_byte_assembler_prefix_classify u_classify (
    .in_byte   (bus.in_byte),
    .is_prefix (is_prefix),
    .grp       (grp),
    .seg_code  (seg_code)
  );

  // Per-byte classification in the context of the current state.
  logic accept, pfx_byte, esc_byte, store_body, clear;
  logic pfx_overflow, no_opcode, body_overflow, len_overflow, fatal_err, strict_err;

  assign accept        = bus.in_valid && in_ready_w;
  assign pfx_byte      = (state_q == S_PREFIX) && is_prefix;
  assign esc_byte      = (state_q == S_PREFIX) && (bus.in_byte == ESC_0F);
  assign pfx_overflow  = pfx_byte && (prefix_cnt_q == PFX_FULL);
  assign no_opcode     = (pfx_byte || esc_byte) && bus.in_last;
  assign body_overflow = (state_q == S_BODY) && (body_cnt_q == BODY_FULL);
  assign len_overflow  = (len_q == 4'hF);
  assign fatal_err     = pfx_overflow || no_opcode || body_overflow || len_overflow;
  assign clear         = (state_q == S_EMIT) && bus.out_ready;

  assign store_body = accept &&
                      (((state_q == S_PREFIX) && !is_prefix && !esc_byte) ||
                       (state_q == S_ESC) ||
                       ((state_q == S_BODY) && !body_overflow));

`ifdef INSTR_STRICT_PREFIX_EN
  logic [GRP_W-1:0] used_grp;
  assign used_grp[GRP_LOCKREP]  = lock_q || rep_q || repne_q;
  assign used_grp[GRP_SEG]      = (seg_q != SEG_NONE);
  assign used_grp[GRP_OPSIZE]   = op16_q;
  assign used_grp[GRP_ADDRSIZE] = addr16_q;
  // A repeated group only flags the instruction; assembly carries on normally.
  assign strict_err = pfx_byte && |(grp & used_grp);
`else
  assign strict_err = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_PREFIX;
    else     state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    if (state_q == S_EMIT) begin
      if (bus.out_ready) state_d = S_PREFIX;
    end else if (accept) begin
      if (bus.in_last) begin
        state_d = S_EMIT;
      end else if (fatal_err) begin
        state_d = S_DRAIN;
      end else begin
        case (state_q)
          S_PREFIX: begin
            if (esc_byte)        state_d = S_ESC;
            else if (!is_prefix) state_d = S_BODY;
          end
          S_ESC:   state_d = S_BODY;
          default: state_d = state_q;
        endcase
      end
    end
  end

  // Output decode from the state register.
  always_comb begin
    in_ready_w  = 1'b1;
    out_valid_w = 1'b0;
    if (state_q == S_EMIT) begin
      in_ready_w  = 1'b0;
      out_valid_w = 1'b1;
    end
  end

  // Datapath: flags, counters and body buffer, cleared when decode takes the word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst || clear) begin
      body_q       <= '0;
      body_cnt_q   <= '0;
      prefix_cnt_q <= '0;
      len_q        <= '0;
      esc_q        <= 1'b0;
      op16_q       <= 1'b0;
      addr16_q     <= 1'b0;
      lock_q       <= 1'b0;
      rep_q        <= 1'b0;
      repne_q      <= 1'b0;
      seg_q        <= SEG_NONE;
      err_q        <= 1'b0;
    end else if (accept) begin
      len_q <= sat_inc4(len_q);
      if (fatal_err || strict_err) err_q <= 1'b1;
      if (esc_byte) esc_q <= 1'b1;
      if (pfx_byte) begin
        if (prefix_cnt_q != PFX_FULL) prefix_cnt_q <= prefix_cnt_q + PCW'(1);
        if (grp[GRP_OPSIZE])   op16_q   <= 1'b1;
        if (grp[GRP_ADDRSIZE]) addr16_q <= 1'b1;
        if (grp[GRP_SEG])      seg_q    <= seg_code;
        if (grp[GRP_LOCKREP]) begin
          case (bus.in_byte)
            PFX_LOCK:  lock_q  <= 1'b1;
            PFX_REP:   rep_q   <= 1'b1;
            PFX_REPNE: repne_q <= 1'b1;
            default: ;
          endcase
        end
      end
      // body_cnt is still zero in S_PREFIX/S_ESC, so it is the store index everywhere.
      if (store_body) begin
        body_cnt_q <= body_cnt_q + BCW'(1);
        for (int i = 0; i < BODY_BYTES; i++) begin
          if (body_cnt_q == BCW'(i)) body_q[8*i +: 8] <= bus.in_byte;
        end
      end
    end
  end

  assign bus.in_ready             = in_ready_w;
  assign bus.out_valid            = out_valid_w;
  assign bus.unescaped_instr      = body_q;
  assign bus.instr_len            = len_q;
  assign bus.is_escaped           = esc_q;
  assign bus.prefix_operand_16bit = op16_q;
  assign bus.prefix_address_16bit = addr16_q;
  assign bus.prefix_lock          = lock_q;
  assign bus.prefix_rep           = rep_q;
  assign bus.prefix_repne         = repne_q;
  assign bus.prefix_seg           = seg_q;
  assign bus.err                  = err_q;
  assign bus.state_dbg            = state_q;

endmodule

// File: doc/instr_byte_assembler.md
Name: instr_byte_assembler

Overview:
- Upstream neighbour of the operand decoder.
- Accepts one raw x86 instruction byte per cycle from the trace/fetch stream, classifies and strips legacy prefixes and the 0x0F escape, and packs the remaining bytes into the unescaped instruction word.
- Hands that word, prefix flags and length to decode over a valid/ready handshake.
- One instruction in flight; the end of each instruction is marked by the upstream `in_last` flag.

Parameters:
- BODY_BYTES, 9: capacity of the body buffer in bytes; `unescaped_instr` width is 8*BODY_BYTES.
- MAX_PREFIXES, 4: maximum number of legacy prefix bytes accepted before the instruction is flagged as an error.

Ports:
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-high
- in_byte  in  8  raw instruction byte
- in_valid  in  1  `in_byte` valid
- in_last  in  1  `in_byte` is the final byte of the instruction
- in_ready  out  1  block accepts a byte this cycle
- out_valid  out  1  assembled instruction available
- out_ready  in  1  decode consumes the instruction
- unescaped_instr  out  8*BODY_BYTES  body bytes; body byte i at [8i+7:8i]; opcode in [7:0]; unused bytes zero
- instr_len  out  4  total bytes accepted, including prefixes and escape; saturates at 15
- is_escaped  out  1  0x0F escape seen
- prefix_operand_16bit  out  1  0x66 seen
- prefix_address_16bit  out  1  0x67 seen
- prefix_lock  out  1  0xF0 seen
- prefix_rep  out  1  0xF3 seen
- prefix_repne  out  1  0xF2 seen
- prefix_seg  out  3  segment override: 0 none, 1 ES, 2 CS, 3 SS, 4 DS, 5 FS, 6 GS
- err  out  1  malformed or oversize instruction

Behaviour:
- Byte transfer happens when `in_valid && in_ready`.
- `in_ready` is 1 in every state except S_EMIT; it is registered from the state.
- States: S_PREFIX (reset state), S_ESC, S_BODY, S_DRAIN, S_EMIT.
- Reset: state S_PREFIX, all counters zero, the body buffer zeroed, every output 0 (`in_ready` = 1).
- S_PREFIX:
  - Prefix byte (66, 67, F0, F2, F3, 26, 2E, 36, 3E, 64, 65): set the matching flag and increment `prefix_cnt`. Segment override is last-wins.
  - If `prefix_cnt` already equals MAX_PREFIXES: set `err`.
  - Byte 0F: set `is_escaped`, go to S_ESC.
  - Any other byte: store as body[0] (`body_cnt` = 1), go to S_BODY.
- S_ESC: the next byte is stored as body[0]; the 0x0F itself is never stored. Go to S_BODY.
- S_BODY:
  - Store the byte at body[`body_cnt`] and increment `body_cnt`.
  - If `body_cnt` == BODY_BYTES before the store: discard the byte and set `err`.
- S_DRAIN: discard bytes; count length only.
- Any accepted byte with `in_last` = 1 moves to S_EMIT.
  - `in_last` on a prefix byte or on the 0F byte (no opcode present): set `err`.
- Any accepted byte that sets `err` without `in_last`: go to S_DRAIN.
- `instr_len` increments on every accepted byte and saturates at 15. A 16th byte sets `err`.
- S_EMIT:
  - `out_valid` = 1 in the cycle after the last byte is accepted, i.e. latency 1.
  - All outputs are held stable while `out_valid && !out_ready`.
  - On `out_ready`: next cycle `out_valid` = 0, all flags, counters and the buffer are cleared, and the state returns to S_PREFIX.
- Throughput: N bytes take N+1 cycles per instruction, with no overlap between instructions.
- Reset mid-instruction: the partial instruction is dropped; upstream restarts from the first byte.
- `in_valid` low: no state change in any state.

Optional Feature:
- Macro: INSTR_STRICT_PREFIX_EN.
- When defined: a second prefix from an already-used group sets `err`. The groups are: lock/rep (F0, F2, F3), segment, 66, 67. The instruction is still assembled and emitted.
- When undefined: repeats are silently merged, with last-wins for the segment override.

Decomposition:
- Shared defines/package:
  - prefix byte constants: PFX_OPSIZE, PFX_ADDRSIZE, PFX_LOCK, PFX_REP, PFX_REPNE, PFX_SEG_*, ESC_0F;
  - SEG_* encodings;
  - state encodings S_*.
- Sub-module `prefix_classify`: combinational. Takes byte → is_prefix, group one-hot, seg code.

Test Plan:
- 01 D8 (last) → `unescaped_instr[15:0]` = 16'hD801, upper bytes 0, `instr_len` = 2, `err` = 0, all prefix flags 0, `out_valid` the cycle after D8.
- 66 0F AF C3 → `is_escaped` = 1, `prefix_operand_16bit` = 1, `[15:0]` = 16'hC3AF, `instr_len` = 4.
- 64 A1 78 56 34 12 with `out_ready` held low 5 cycles → outputs stable, `in_ready` = 0 throughout; `prefix_seg` = 5. Accept, and `in_ready` returns to 1 the next cycle.
- 10 body bytes 00..09 → `err` = 1, body = 00..08, `instr_len` = 10.
- F3 F3 90:
  - without INSTR_STRICT_PREFIX_EN → `err` = 0, `prefix_rep` = 1;
  - with INSTR_STRICT_PREFIX_EN → `err` = 1.
- 5× 2E then 90 → `err` = 1. Assert `rst` after 2 bytes of a later instruction → `out_valid` = 0 immediately; the following 90 (last) emits clean with `instr_len` = 1.
